// File: rtl/pwm_capture.sv
// pwm_capture: measures a PWM waveform in the clk_pwm domain and reports the high time, the
// period and an 8-bit duty code on the pwm_set scale of the generator (N means N/256).
//
// Ports:
//   clk_pwm    - sampling clock
//   rst_n      - asynchronous active-low reset
//   en         - capture enable; low forces the FSM to idle and aborts any division
//   pwm_in     - asynchronous PWM input
//   high_cnt   - cycles high in the last valid period
//   period_cnt - cycles between the last two rising edges
//   duty       - floor(high_cnt * 256 / period_cnt)
//   meas_valid - one-cycle pulse when high_cnt/period_cnt/duty update
//   sig_lost   - level, no rising edge within TIMEOUT cycles
//   err        - one-cycle pulse, period too short and measurement dropped
module pwm_capture #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 65535
) (
  input  logic             clk_pwm,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic [7:0]       duty,
  output logic             meas_valid,
  output logic             sig_lost,
  output logic             err
);

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  // Synchronizer and edge detection
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, p_q, rise, fall;

  always_ff @(posedge clk_pwm or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      p_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      p_q    <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~p_q;
  assign fall = ~s & p_q;

  // Cycle counter: reads H at the fall and H+L at the next rise
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout;

  assign timeout = (cnt_q == TimeoutVal);

  always_comb begin
    cnt_d = cnt_q;
    if (!en)           cnt_d = '0;
    else if (rise)     cnt_d = CNT_W'(1);
    else if (!timeout) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_pwm or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Measurement FSM
  state_e state_q, state_d;
  logic   busy_q;
  logic   capture_h, div_start, short_err, lose;

  always_ff @(posedge clk_pwm or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (rise) state_d = StHigh;
        StHigh: begin
          if (timeout)   state_d = StIdle;
          else if (fall) state_d = StLow;
        end
        StLow: begin
          if (rise)         state_d = StHigh;
          else if (timeout) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    capture_h = en & (state_q == StHigh) & fall & ~timeout;
    div_start = en & (state_q == StLow) & rise & ~busy_q;
    short_err = en & (state_q == StLow) & rise & busy_q;
    lose      = en & ((state_q == StHigh) | (state_q == StLow)) & timeout & ~rise;
  end

  logic [CNT_W-1:0] h_q;

  always_ff @(posedge clk_pwm or negedge rst_n) begin
    if (!rst_n)         h_q <= '0;
    else if (capture_h) h_q <= cnt_q;
  end

  // Restoring divider: steps 0..7 produce quotient bits MSB first; step 8 is a tail cycle that
  // keeps the divider busy so the minimum accepted period is 10 cycles.
  logic [3:0]       step_q;
  logic [CNT_W:0]   rem_q, rem_sh, rem_nx;
  logic [CNT_W-1:0] den_q, num_q;
  logic [7:0]       quot_q, quot_nx;
  logic             q_bit, last_step;

  assign rem_sh    = rem_q << 1;
  assign q_bit     = (rem_sh >= {1'b0, den_q});
  assign rem_nx    = q_bit ? (rem_sh - {1'b0, den_q}) : rem_sh;
  assign quot_nx   = {quot_q[6:0], q_bit};
  assign last_step = busy_q & (step_q == 4'd7);

  always_ff @(posedge clk_pwm or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      step_q <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      num_q  <= '0;
      quot_q <= '0;
    end else if (!en) begin
      busy_q <= 1'b0;
      step_q <= '0;
    end else if (div_start) begin
      busy_q <= 1'b1;
      step_q <= '0;
      rem_q  <= {1'b0, h_q};
      den_q  <= cnt_q;
      num_q  <= h_q;
      quot_q <= '0;
    end else if (busy_q) begin
      if (step_q == 4'd8) begin
        busy_q <= 1'b0;
      end else begin
        rem_q  <= rem_nx;
        quot_q <= quot_nx;
        step_q <= step_q + 4'd1;
      end
    end
  end

  // Result registers
  always_ff @(posedge clk_pwm or negedge rst_n) begin
    if (!rst_n) begin
      high_cnt   <= '0;
      period_cnt <= '0;
      duty       <= '0;
      meas_valid <= 1'b0;
      sig_lost   <= 1'b0;
      err        <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      err        <= short_err;
      if (en && last_step) begin
        high_cnt   <= num_q;
        period_cnt <= den_q;
        duty       <= quot_nx;
        meas_valid <= 1'b1;
        sig_lost   <= 1'b0;
      end else if (lose) begin
        sig_lost <= 1'b1;
        duty     <= s ? 8'hFF : 8'h00;
      end
    end
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Measures an incoming PWM waveform sampled in the clk_pwm domain and reports high time, period and an 8-bit duty code.
- The 8-bit duty code uses the same scale as the pwm_set input of the generator, so a value of N means N/256 duty.
- Used for servo/ESC feedback and RC-receiver channel decoding, and as the loopback checker for the generator.
- Contains an input synchronizer, an edge-driven measurement FSM, a timeout watchdog and an 8-cycle sequential restoring divider.

Parameters:
- CNT_W, 16: width of the cycle counter and of the high_cnt/period_cnt outputs.
- SYNC_STAGES, 2: number of synchronizer flops on pwm_in; minimum 2.
- TIMEOUT, 65535: number of cycles without a rising edge before sig_lost asserts. Must be ≤ 2^CNT_W−1.

Ports:
- clk_pwm, input, 1: sampling clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- en, input, 1: capture enable.
- pwm_in, input, 1: asynchronous PWM input.
- high_cnt, output, CNT_W: cycles high in the last valid period.
- period_cnt, output, CNT_W: cycles between the last two rising edges.
- duty, output, 8: floor(high_cnt*256/period_cnt).
- meas_valid, output, 1: one-cycle pulse when the three result outputs update.
- sig_lost, output, 1: level; no rising edge within TIMEOUT cycles.
- err, output, 1: one-cycle pulse; period too short, measurement dropped.

Behaviour:
- Reset: all synchronizer flops, counter, FSM and divider clear to 0 and the FSM enters IDLE. Outputs reset to high_cnt=0, period_cnt=0, duty=0, meas_valid=0, sig_lost=0, err=0.
- Synchronizer: pwm_in passes through SYNC_STAGES flops to give s. A registered copy p of s is kept.
  - rise = s & ~p
  - fall = ~s & p
  - Synchronizer latency does not affect measured widths.
- Counter cnt:
  - Loads 1 in the cycle after a rise.
  - Otherwise increments each cycle, saturating at TIMEOUT.
  - With synced high H cycles and low L cycles: cnt equals H at fall and H+L at the next rise.
- FSM states:
  - IDLE: waiting for the first rise. That rise only arms the block (the partial first period is discarded) and moves to HIGH.
  - HIGH → LOW on fall; the captured high value h := cnt.
  - LOW → HIGH on rise; this closes a period with P := cnt.
  - If the divider is idle, it starts with num=h, den=P.
- Divider (restoring, quotient < 256 because h < P):
  - Start: rem := h.
  - Each of 8 cycles: rem := rem<<1; if rem ≥ P then rem −= P and the quotient bit is 1, otherwise 0, MSB first.
  - rem is CNT_W+1 bits wide.
- Result update: high_cnt, period_cnt and duty update together, and meas_valid pulses, exactly 9 cycles after the rise that closed the period.
  - The same update clears sig_lost.
- Short period: a rise while the divider is busy (P < 10) drops that measurement and pulses err for 1 cycle.
  - cnt and the FSM still resynchronize to the new rise.
  - The divider run in progress completes normally.
- Timeout: if cnt reaches TIMEOUT in HIGH or LOW:
  - sig_lost=1 and the FSM goes to IDLE.
  - duty is forced to 8'hFF if s=1, otherwise 8'h00.
  - high_cnt and period_cnt hold their values; no meas_valid pulse.
  - The next two rises re-arm the block and produce a measurement.
- A fall in IDLE is ignored.
- A rise and a timeout cannot coincide, because cnt reloads on a rise; rise has priority.
- en=0: FSM forced to IDLE and the divider aborts with no meas_valid. cnt is held at 0 and outputs hold. Re-enabling requires re-arming.
- Reset mid-division: the result is discarded with no meas_valid pulse and outputs return to their reset values.

Test Plan:
- Loopback with the generator at pwm_set=64 (high 64, period 256 clk_pwm cycles) → first meas_valid after the second rise, 9 cycles after it; high_cnt=64, period_cnt=256, duty=64; repeats every 256 cycles.
- pwm_in high 100, low 200 → period_cnt=300, high_cnt=100, duty=85. Check high 1, low 299 → duty=0; high 299, low 1 → duty=255.
- pwm_in held low with TIMEOUT=1000 after valid pulses → sig_lost rises when cnt reaches 1000 and duty=0. Held high → duty=8'hFF. Resuming a 256-cycle PWM → sig_lost clears on the first new meas_valid.
- Period of 7 cycles (high 3, low 4) immediately after a 256-cycle measurement → the in-flight result still posts, err pulses, and no meas_valid occurs for the short period.
- rst_n low 4 cycles after a rise that starts a division → no meas_valid; all outputs at 0. After release, the next meas_valid follows the second clean rise.
- en dropped mid-period, then restored → outputs hold while en=0; the first post-enable period is discarded; correct values follow.
